// File: rtl/cp0_tlb_seq.sv
// rtl/cp0_tlb_seq.sv - sequences TLBP/TLBR/TLBWI from WB into the CP0 TLB interface
module cp0_tlb_seq #(
    parameter int TLBP_LAT = 2,
    parameter int TLBR_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    input  logic        exc_flush,
    output logic [2:0]  tlb_op,
    output logic        tlb_busy,
    output logic        done,
    output logic        refetch_valid,
    output logic [31:0] refetch_pc
);

    // One-hot bit positions of the TLB operations on req_op / tlb_op.
    localparam int TLBOP_TLBP  = 0;
    localparam int TLBOP_TLBR  = 1;
    localparam int TLBOP_TLBWI = 2;

    localparam logic [2:0] OP_TLBP  = 3'(1 << TLBOP_TLBP);
    localparam logic [2:0] OP_TLBR  = 3'(1 << TLBOP_TLBR);
    localparam logic [2:0] OP_TLBWI = 3'(1 << TLBOP_TLBWI);

    localparam int MAX_LAT = (TLBP_LAT > TLBR_LAT) ? TLBP_LAT : TLBR_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [2:0]     op_q;
    logic [31:0]    pc_q;
    logic [31:0]    rpc_q;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic [CW-1:0]  lat_m1;
    logic           op_legal;
    logic           op_refetch;
    logic           accept;

    // Decode the latched op: legality, remaining-latency preload, and refetch need.
    always_comb begin
        op_legal   = (op_q == OP_TLBP) || (op_q == OP_TLBR) || (op_q == OP_TLBWI);
        op_refetch = (op_q == OP_TLBWI) || (op_q == OP_TLBR);
        lat_m1     = '0;
        if (op_q == OP_TLBP) begin
            lat_m1 = CW'(TLBP_LAT - 1);
        end else if (op_q == OP_TLBR) begin
            lat_m1 = CW'(TLBR_LAT - 1);
        end
    end

    // Next-state and pulse outputs; everything is forced quiet while reset is held.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        tlb_op        = 3'b000;
        done          = 1'b0;
        refetch_valid = 1'b0;
        req_ready     = 1'b0;
        accept        = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = ~exc_flush;
                if (req_valid && !exc_flush) begin
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Illegal (zero or multi-hot) ops run the sequence without touching the TLB.
                tlb_op     = op_legal ? op_q : 3'b000;
                cnt_next   = lat_m1;
                state_next = (lat_m1 != '0) ? S_WAIT : S_DONE;
            end
            S_WAIT: begin
                cnt_next = cnt - CW'(1);
                if (cnt_next == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done          = 1'b1;
                refetch_valid = op_legal && op_refetch && !exc_flush;
                state_next    = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (!resetn) begin
            tlb_op        = 3'b000;
            done          = 1'b0;
            refetch_valid = 1'b0;
            req_ready     = 1'b0;
            accept        = 1'b0;
        end
    end

    assign tlb_busy   = resetn && (state != S_IDLE);
    assign refetch_pc = resetn ? rpc_q : 32'h0000_0000;

    // State, latency counter, latched request and the held refetch target.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= 3'b000;
            pc_q  <= 32'h0000_0000;
            rpc_q <= 32'h0000_0000;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                op_q <= req_op;
                pc_q <= req_pc;
            end
            // Load the target on entry to DONE so it is visible during the DONE cycle.
            if (state != S_DONE && state_next == S_DONE) begin
                rpc_q <= pc_q + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_cp0_tlb_seq.sv
// tb/tb_cp0_tlb_seq.sv - self-checking bench for cp0_tlb_seq
module tb_cp0_tlb_seq;

    localparam int P_LAT = 2;
    localparam int R_LAT = 1;
    localparam logic [2:0] OP_P  = 3'b001;
    localparam logic [2:0] OP_R  = 3'b010;
    localparam logic [2:0] OP_WI = 3'b100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_pc = 32'h0;
    logic        req_ready;
    logic        exc_flush = 1'b0;
    logic [2:0]  tlb_op;
    logic        tlb_busy;
    logic        done;
    logic        refetch_valid;
    logic [31:0] refetch_pc;

    int checks = 0;
    int failures = 0;

    cp0_tlb_seq #(.TLBP_LAT(P_LAT), .TLBR_LAT(R_LAT)) dut (
        .clk(clk),
        .resetn(resetn),
        .req_valid(req_valid),
        .req_op(req_op),
        .req_pc(req_pc),
        .req_ready(req_ready),
        .exc_flush(exc_flush),
        .tlb_op(tlb_op),
        .tlb_busy(tlb_busy),
        .done(done),
        .refetch_valid(refetch_valid),
        .refetch_pc(refetch_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    // Schedule-based model: an accepted instruction owns absolute cycles
    // [accept+1, accept+1+L]; pulses are placed on those cycle numbers.
    int          cyc = 0;
    bit          started = 0;
    bit          active = 0;
    int          t_issue = 0;
    int          t_done = 0;
    logic [2:0]  m_op = 3'b000;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] rpc_hold = 32'h0;

    function automatic int lat_of(input logic [2:0] op);
        if (op == OP_P) return P_LAT;
        if (op == OP_R) return R_LAT;
        return 1;
    endfunction

    function automatic bit legal(input logic [2:0] op);
        return (op == OP_P) || (op == OP_R) || (op == OP_WI);
    endfunction

    always @(posedge clk) begin
        started = 1;
        if (!resetn) begin
            active   = 0;
            rpc_hold = 32'h0;
        end else if (active) begin
            if (cyc == t_done) begin
                active   = 0;
                rpc_hold = m_pc + 32'd4;
            end
        end else if (req_valid && !exc_flush) begin
            active  = 1;
            m_op    = req_op;
            m_pc    = req_pc;
            t_issue = cyc + 1;
            t_done  = cyc + 1 + lat_of(req_op);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            logic [2:0]  e_op;
            logic        e_done;
            logic        e_ref;
            logic [31:0] e_rpc;
            e_op   = (resetn && active && cyc == t_issue && legal(m_op)) ? m_op : 3'b000;
            e_done = resetn && active && cyc == t_done;
            e_ref  = e_done && (m_op == OP_WI || m_op == OP_R) && !exc_flush;
            e_rpc  = !resetn ? 32'h0 : (e_done ? m_pc + 32'd4 : rpc_hold);
            chk("m_tlb_op", 32'(tlb_op), 32'(e_op));
            chk("m_busy", 32'(tlb_busy), 32'(resetn && active));
            chk("m_ready", 32'(req_ready), 32'(resetn && !active && !exc_flush));
            chk("m_done", 32'(done), 32'(e_done));
            chk("m_refetch", 32'(refetch_valid), 32'(e_ref));
            chk("m_refetch_pc", refetch_pc, e_rpc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns cycles spent waiting.
    task automatic send(input logic [2:0] op, input logic [31:0] pc, output int waited);
        req_valid = 1'b1;
        req_op    = op;
        req_pc    = pc;
        waited    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waited++;
            if (req_ready) break;
        end
        chk("send_accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_pc    = 32'h0;
    endtask

    initial begin
        int w;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_busy", 32'(tlb_busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_refetch_pc", refetch_pc, 32'h0);
        tick();
        resetn = 1'b1;
        tick();

        // TLBWI: pulse at T1, done/refetch at T2
        send(OP_WI, 32'h8000_1000, w);
        chk("wi_wait", 32'(w), 32'd1);
        @(negedge clk);
        chk("wi_t1_op", 32'(tlb_op), 32'h4);
        chk("wi_t1_busy", 32'(tlb_busy), 32'd1);
        @(negedge clk);
        chk("wi_t2_done", 32'(done), 32'd1);
        chk("wi_t2_ref", 32'(refetch_valid), 32'd1);
        chk("wi_t2_pc", refetch_pc, 32'h8000_1004);
        @(negedge clk);
        chk("wi_t3_busy", 32'(tlb_busy), 32'd0);
        tick();

        // TLBP: two-cycle latency, never refetches
        send(OP_P, 32'h0040_0000, w);
        @(negedge clk);
        chk("p_t1_op", 32'(tlb_op), 32'h1);
        @(negedge clk);
        chk("p_t2_done", 32'(done), 32'd0);
        chk("p_t2_busy", 32'(tlb_busy), 32'd1);
        @(negedge clk);
        chk("p_t3_done", 32'(done), 32'd1);
        chk("p_t3_ref", 32'(refetch_valid), 32'd0);
        tick();

        // TLBR at top of address space: refetch_pc wraps
        send(OP_R, 32'hFFFF_FFFC, w);
        @(negedge clk);
        chk("r_t1_op", 32'(tlb_op), 32'h2);
        @(negedge clk);
        chk("r_t2_done", 32'(done), 32'd1);
        chk("r_t2_ref", 32'(refetch_valid), 32'd1);
        chk("r_t2_pc", refetch_pc, 32'h0000_0000);
        tick();

        // Request with exc_flush is refused; back-to-back request waits out busy
        exc_flush = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_WI;
        req_pc    = 32'h0000_0100;
        @(negedge clk);
        chk("fl_ready", 32'(req_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("fl_no_op", 32'(tlb_op), 32'h0);
        chk("fl_no_busy", 32'(tlb_busy), 32'd0);
        tick();
        exc_flush = 1'b0;
        send(OP_WI, 32'h0000_0100, w);
        chk("b2b_first_wait", 32'(w), 32'd1);
        send(OP_P, 32'h0000_0200, w);
        chk("b2b_second_wait", 32'(w), 32'd3);
        repeat (4) tick();

        // Reset during TLBP WAIT aborts silently
        send(OP_P, 32'h0000_0300, w);
        @(negedge clk);
        tick();
        resetn = 1'b0;
        @(negedge clk);
        chk("ab_op", 32'(tlb_op), 32'h0);
        chk("ab_busy", 32'(tlb_busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_ready", 32'(req_ready), 32'd0);
        chk("ab_pc", refetch_pc, 32'h0);
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("ab_after_busy", 32'(tlb_busy), 32'd0);
        chk("ab_after_done", 32'(done), 32'd0);
        tick();

        // Multi-hot op runs as a no-op
        send(3'b011, 32'h0000_0400, w);
        @(negedge clk);
        chk("ill_t1_op", 32'(tlb_op), 32'h0);
        chk("ill_t1_busy", 32'(tlb_busy), 32'd1);
        @(negedge clk);
        chk("ill_t2_done", 32'(done), 32'd1);
        chk("ill_t2_ref", 32'(refetch_valid), 32'd0);
        tick();

        // exc_flush in DONE of TLBWI kills only the refetch
        send(OP_WI, 32'h0000_0500, w);
        @(negedge clk);
        tick();
        exc_flush = 1'b1;
        @(negedge clk);
        chk("xf_done", 32'(done), 32'd1);
        chk("xf_ref", 32'(refetch_valid), 32'd0);
        chk("xf_pc", refetch_pc, 32'h0000_0504);
        tick();
        exc_flush = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
